imem_load_ctrl: RTL and testbench
=================================

# imem_load_ctrl

Sequencer that shares the single-ported instruction memory between the fetch stage and an external program-loader stream. In RUN it passes the fetch PC through to the memory. In LOAD it stalls fetch, writes streamed words to consecutive addresses from BOOT_ADDR, then flushes decode and restarts the PC at BOOT_ADDR. It sits between the fetch stage, the instruction memory and the loader (UART/debug bridge).

## Interface
- ADDRESS_WIDTH, 32, byte address width.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH_LOG2, 8, log2 of instruction memory capacity in words.
- BOOT_ADDR, 32'h0, byte address of the first loaded word and the PC restart value; word aligned.

- i_CLK  in  1  clock, all state on rising edge.
- i_RST  in  1  synchronous, active-low reset.
- i_LdStart  in  1  request to enter LOAD; sampled in RUN only.
- i_LdValid  in  1  loader word valid.
- i_LdData  in  INSTR_WIDTH  loader word.
- i_LdLast  in  1  qualifies the final word of a load; meaningful only with i_LdValid.
- o_LdReady  out  1  controller accepts a loader word.
- i_PCF  in  ADDRESS_WIDTH  fetch-stage PC.
- o_MemAddr  out  ADDRESS_WIDTH  instruction memory byte address.
- o_MemWData  out  INSTR_WIDTH  instruction memory write data.
- o_MemWE  out  1  instruction memory write enable.
- o_StallF  out  1  freezes the fetch PC register.
- o_FlushD  out  1  clears the fetch/decode pipeline register.
- o_PCRst  out  1  forces the PC to BOOT_ADDR on the next edge.
- o_Busy  out  1  high in any state other than RUN.
- o_WordCount  out  DEPTH_LOG2+1  words written in the current or last load.
- o_Err  out  1  sticky overflow flag.

## Operation
- States: RUN, LOAD, FLUSH.
- Handshake: a word transfers on a cycle with i_LdValid & o_LdReady.
- RUN
  - o_MemAddr = i_PCF; o_MemWE = 0; o_LdReady = 0; o_StallF = 0.
  - i_LdStart = 1 moves to LOAD, clears o_WordCount and clears o_Err.
- LOAD
  - o_LdReady = 1; o_StallF = 1.
  - o_MemAddr = BOOT_ADDR + 4·o_WordCount, computed in ADDRESS_WIDTH bits with wrap.
  - o_MemWData = i_LdData.
  - o_MemWE = handshake & (o_WordCount < 2^DEPTH_LOG2).
  - On a handshake, o_WordCount increments while below 2^DEPTH_LOG2. At the cap it saturates, the word is dropped with no write, and o_Err sets.
  - A handshake with i_LdLast = 1 moves to FLUSH, including an overflowing last word.
  - i_LdStart is ignored in LOAD.
- FLUSH
  - Lasts exactly one cycle. o_StallF = 1, o_FlushD = 1, o_PCRst = 1, o_LdReady = 0, o_MemAddr = i_PCF.
  - Unconditionally returns to RUN.
- o_Busy = (state != RUN).
- o_Err stays set until reset or the next i_LdStart accepted in RUN.
- A load with zero valid words cannot complete. It ends only with a handshake carrying i_LdLast, or with reset.

## Timing
- State, o_WordCount and o_Err are registered.
- All other outputs are combinational decodes of the state register, o_WordCount and the inputs. This gives single-cycle write latency: a word accepted on edge N is written by memory at edge N.
- RUN→LOAD: o_StallF is high in the cycle after the i_LdStart sample.
- A last-word handshake at edge N is followed by the FLUSH cycle N..N+1. The PC equals BOOT_ADDR after edge N+1, and RUN starts at N+1.
- Reset (i_RST = 0 at an edge) yields the reset state, o_WordCount = 0 and o_Err = 0. Combinational outputs follow that state.
- Reset mid-LOAD abandons the load immediately; already written words remain in memory.
- Simultaneous i_LdStart and i_LdValid in RUN: the word is not accepted, because o_LdReady is 0 in RUN.

## Configuration
- BOOT_LOAD_EN
  - Defined: the reset state is LOAD. The core stays stalled after reset until a program has been streamed in.
  - Undefined: the reset state is RUN and the core executes preloaded memory contents.
  - All other behaviour is identical in both builds.

## Test plan
- Reset with BOOT_LOAD_EN undefined, i_PCF = 0x40 → o_MemAddr = 0x40, o_StallF = 0, o_Busy = 0, o_WordCount = 0, o_Err = 0.
- Pulse i_LdStart, then stream 3 words 0x11, 0x22, 0x33 (last flagged) with BOOT_ADDR = 0 → writes at 0x0, 0x4, 0x8; then one FLUSH cycle with o_FlushD = o_PCRst = 1; RUN; o_WordCount = 3.
- Loader with i_LdValid toggling every other cycle → only handshake cycles assert o_MemWE; addresses remain contiguous.
- DEPTH_LOG2 = 2, stream 6 words, last flagged → 4 writes (0x0 to 0xC), o_WordCount = 4, o_Err = 1, FLUSH still occurs; next i_LdStart clears o_Err.
- Assert i_RST = 0 after 2 of 5 words → next cycle in the reset state, o_WordCount = 0, no further writes. With BOOT_LOAD_EN defined, o_LdReady = 1 and o_StallF = 1 directly out of reset.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction memory port arbiter: passes the fetch PC through in RUN, streams loader words
// from BOOT_ADDR in LOAD, then flushes decode and restarts the PC. Macro: BOOT_LOAD_EN.
module imem_load_ctrl #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              INSTR_WIDTH   = 32,
   parameter int unsigned              DEPTH_LOG2    = 8,
   parameter logic [ADDRESS_WIDTH-1:0] BOOT_ADDR     = '0
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_LdStart,
   input  logic                     i_LdValid,
   input  logic [INSTR_WIDTH-1:0]   i_LdData,
   input  logic                     i_LdLast,
   output logic                     o_LdReady,
   input  logic [ADDRESS_WIDTH-1:0] i_PCF,
   output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
   output logic [INSTR_WIDTH-1:0]   o_MemWData,
   output logic                     o_MemWE,
   output logic                     o_StallF,
   output logic                     o_FlushD,
   output logic                     o_PCRst,
   output logic                     o_Busy,
   output logic [DEPTH_LOG2:0]      o_WordCount,
   output logic                     o_Err
);

   typedef enum logic [1:0] {StRun, StLoad, StFlush} state_e;

`ifdef BOOT_LOAD_EN
   localparam state_e ResetState = StLoad;
`else
   localparam state_e ResetState = StRun;
`endif

   localparam logic [DEPTH_LOG2:0] WordCap = {1'b1, {DEPTH_LOG2{1'b0}}};

   state_e                     state_q, state_d;
   logic [DEPTH_LOG2:0]        wc_q, wc_d;
   logic                       err_q, err_d;
   logic                       below_cap;
   logic [ADDRESS_WIDTH-1:0]   load_addr;

   assign below_cap = (wc_q < WordCap);
   // Word index scaled to a byte offset; the sum wraps in ADDRESS_WIDTH bits.
   assign load_addr = BOOT_ADDR + (ADDRESS_WIDTH'(wc_q) << 2);

   always_comb begin
      state_d    = state_q;
      wc_d       = wc_q;
      err_d      = err_q;
      o_LdReady  = 1'b0;
      o_StallF   = 1'b0;
      o_FlushD   = 1'b0;
      o_PCRst    = 1'b0;
      o_MemAddr  = i_PCF;
      o_MemWData = i_LdData;
      o_MemWE    = 1'b0;
      unique case (state_q)
         StRun: begin
            if (i_LdStart) begin
               state_d = StLoad;
               wc_d    = '0;
               err_d   = 1'b0;
            end
         end
         StLoad: begin
            o_LdReady = 1'b1;
            o_StallF  = 1'b1;
            o_MemAddr = load_addr;
            o_MemWE   = i_LdValid & below_cap;
            if (i_LdValid) begin
               // Words past capacity are dropped but still flag the overflow.
               if (below_cap) wc_d  = wc_q + 1'b1;
               else           err_d = 1'b1;
               if (i_LdLast) state_d = StFlush;
            end
         end
         StFlush: begin
            o_StallF = 1'b1;
            o_FlushD = 1'b1;
            o_PCRst  = 1'b1;
            state_d  = StRun;
         end
         default: state_d = ResetState;
      endcase
   end

   assign o_Busy      = (state_q != StRun);
   assign o_WordCount = wc_q;
   assign o_Err       = err_q;

   always_ff @(posedge i_CLK) begin
      if (!i_RST) begin
         state_q <= ResetState;
         wc_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: two instances (small depth / wrapping boot address) checked against
// a behavioural model every cycle, plus a vector table and hand-written corner sequences.
module tb_imem_load_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ld_start, ld_valid, ld_last;
   logic [31:0] ld_data, pcf;

   logic [31:0] addr_o  [2];
   logic [31:0] wdata_o [2];
   logic        we_o    [2];
   logic        ready_o [2];
   logic        stall_o [2];
   logic        flush_o [2];
   logic        pcrst_o [2];
   logic        busy_o  [2];
   logic        err_o   [2];
   logic [2:0]  wc0;
   logic [4:0]  wc1;

   int checks = 0;
   int errors = 0;
   int we_cnt0 = 0;

   int unsigned dl   [2] = '{2, 4};
   logic [31:0] boot [2] = '{32'h0, 32'hFFFF_FFF0};

   bit          m_load  [2];
   bit          m_flush [2];
   int unsigned m_cnt   [2];
   bit          m_err   [2];

`ifdef BOOT_LOAD_EN
   localparam bit BootLoad = 1'b1;
`else
   localparam bit BootLoad = 1'b0;
`endif

   imem_load_ctrl #(
      .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH_LOG2(2), .BOOT_ADDR(32'h0)
   ) u0 (
      .i_CLK(clk), .i_RST(rst_n), .i_LdStart(ld_start), .i_LdValid(ld_valid),
      .i_LdData(ld_data), .i_LdLast(ld_last), .o_LdReady(ready_o[0]), .i_PCF(pcf),
      .o_MemAddr(addr_o[0]), .o_MemWData(wdata_o[0]), .o_MemWE(we_o[0]),
      .o_StallF(stall_o[0]), .o_FlushD(flush_o[0]), .o_PCRst(pcrst_o[0]),
      .o_Busy(busy_o[0]), .o_WordCount(wc0), .o_Err(err_o[0])
   );

   imem_load_ctrl #(
      .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .DEPTH_LOG2(4), .BOOT_ADDR(32'hFFFF_FFF0)
   ) u1 (
      .i_CLK(clk), .i_RST(rst_n), .i_LdStart(ld_start), .i_LdValid(ld_valid),
      .i_LdData(ld_data), .i_LdLast(ld_last), .o_LdReady(ready_o[1]), .i_PCF(pcf),
      .o_MemAddr(addr_o[1]), .o_MemWData(wdata_o[1]), .o_MemWE(we_o[1]),
      .o_StallF(stall_o[1]), .o_FlushD(flush_o[1]), .o_PCRst(pcrst_o[1]),
      .o_Busy(busy_o[1]), .o_WordCount(wc1), .o_Err(err_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] wc_of(input int k);
      return (k == 0) ? 32'(wc0) : 32'(wc1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_load[k]  = BootLoad;
         m_flush[k] = 1'b0;
         m_cnt[k]   = 0;
         m_err[k]   = 1'b0;
      end
   endtask

   // One clock: drive inputs just after negedge, check both instances, advance model and clock.
   task automatic cycle(input logic st, input logic v, input logic [31:0] d, input logic l,
                        input logic [31:0] pc);
      ld_start = st; ld_valid = v; ld_data = d; ld_last = l; pcf = pc;
      #1;
      for (int k = 0; k < 2; k++) begin
         int unsigned cap;
         bit          ewe;
         logic [31:0] eaddr;
         cap   = 1 << dl[k];
         ewe   = m_load[k] && v && (m_cnt[k] < cap);
         eaddr = m_load[k] ? boot[k] + 32'(4 * m_cnt[k]) : pc;
         chk($sformatf("u%0d.addr", k),  64'(addr_o[k]),  64'(eaddr));
         chk($sformatf("u%0d.we", k),    64'(we_o[k]),    64'(ewe));
         chk($sformatf("u%0d.ready", k), 64'(ready_o[k]), 64'(m_load[k]));
         chk($sformatf("u%0d.stall", k), 64'(stall_o[k]), 64'(m_load[k] | m_flush[k]));
         chk($sformatf("u%0d.flushd", k), 64'(flush_o[k]), 64'(m_flush[k]));
         chk($sformatf("u%0d.pcrst", k), 64'(pcrst_o[k]), 64'(m_flush[k]));
         chk($sformatf("u%0d.busy", k),  64'(busy_o[k]),  64'(m_load[k] | m_flush[k]));
         chk($sformatf("u%0d.wc", k),    64'(wc_of(k)),   64'(m_cnt[k]));
         chk($sformatf("u%0d.err", k),   64'(err_o[k]),   64'(m_err[k]));
         if (m_load[k]) chk($sformatf("u%0d.wdata", k), 64'(wdata_o[k]), 64'(d));
         if (k == 0 && we_o[0]) we_cnt0++;
         if (!rst_n) begin
            m_load[k] = BootLoad; m_flush[k] = 1'b0; m_cnt[k] = 0; m_err[k] = 1'b0;
         end else if (m_flush[k]) begin
            m_flush[k] = 1'b0;
         end else if (m_load[k]) begin
            if (v) begin
               if (m_cnt[k] < cap) m_cnt[k]++;
               else                m_err[k] = 1'b1;
               if (l) begin
                  m_load[k]  = 1'b0;
                  m_flush[k] = 1'b1;
               end
            end
         end else if (st) begin
            m_load[k] = 1'b1; m_cnt[k] = 0; m_err[k] = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        l;
      logic [31:0] pc;
      logic        we;
      logic [31:0] addr;
      logic        stall, flushd, pcrst, busy;
      logic [2:0]  wc;
      logic        err;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{1'b1, 32'h11, 1'b0, 32'h40, 1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
      tbl[1] = '{1'b0, 32'h0,  1'b0, 32'h40, 1'b0, 32'h4,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
      tbl[2] = '{1'b1, 32'h22, 1'b0, 32'h40, 1'b1, 32'h4,  1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
      tbl[3] = '{1'b1, 32'h33, 1'b1, 32'h40, 1'b1, 32'h8,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0};
      tbl[4] = '{1'b0, 32'h0,  1'b0, 32'h40, 1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0};
      tbl[5] = '{1'b0, 32'h0,  1'b0, 32'h44, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0};

      rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; pcf = 32'h40;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;

      // Out of reset.
      #1;
      chk("rst.addr",  64'(addr_o[0]),  BootLoad ? 64'h0 : 64'h40);
      chk("rst.stall", 64'(stall_o[0]), 64'(BootLoad));
      chk("rst.ready", 64'(ready_o[0]), 64'(BootLoad));
      chk("rst.busy",  64'(busy_o[0]),  64'(BootLoad));
      chk("rst.wc",    64'(wc0),        64'h0);
      chk("rst.err",   64'(err_o[0]),   64'h0);
      if (BootLoad) begin
         cycle(1'b0, 1'b1, 32'hB007, 1'b1, 32'h40);
         cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h40);
      end
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h40);

      // Three-word load with a gap, then FLUSH and RUN.
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h40);
      for (int i = 0; i < 6; i++) begin
         ld_start = 1'b0; ld_valid = tbl[i].v; ld_data = tbl[i].d; ld_last = tbl[i].l;
         pcf = tbl[i].pc;
         #1;
         chk($sformatf("tbl%0d.we", i),     64'(we_o[0]),    64'(tbl[i].we));
         chk($sformatf("tbl%0d.addr", i),   64'(addr_o[0]),  64'(tbl[i].addr));
         chk($sformatf("tbl%0d.stall", i),  64'(stall_o[0]), 64'(tbl[i].stall));
         chk($sformatf("tbl%0d.flushd", i), 64'(flush_o[0]), 64'(tbl[i].flushd));
         chk($sformatf("tbl%0d.pcrst", i),  64'(pcrst_o[0]), 64'(tbl[i].pcrst));
         chk($sformatf("tbl%0d.busy", i),   64'(busy_o[0]),  64'(tbl[i].busy));
         chk($sformatf("tbl%0d.wc", i),     64'(wc0),        64'(tbl[i].wc));
         chk($sformatf("tbl%0d.err", i),    64'(err_o[0]),   64'(tbl[i].err));
         cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].pc);
      end

      // Overflow: six words into a four-word memory.
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h80);
      we_cnt0 = 0;
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 32'(32'hA0 + i), (i == 5), 32'h80);
      ld_valid = 1'b0; ld_last = 1'b0; #1;
      chk("ovf.writes", 64'(we_cnt0),    64'd4);
      chk("ovf.wc",     64'(wc0),        64'd4);
      chk("ovf.err",    64'(err_o[0]),   64'd1);
      chk("ovf.flushd", 64'(flush_o[0]), 64'd1);
      chk("ovf.u1wc",   64'(wc1),        64'd6);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h80);
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h80);
      #1;
      chk("ovf.errclr", 64'(err_o[0]), 64'd0);
      chk("ovf.wcclr",  64'(wc0),      64'd0);

      // Reset after two of five words.
      cycle(1'b0, 1'b1, 32'hC0, 1'b0, 32'h90);
      cycle(1'b0, 1'b1, 32'hC1, 1'b0, 32'h90);
      rst_n = 1'b0;
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h90);
      rst_n = 1'b1;
      ld_valid = 1'b1; ld_data = 32'hC2; #1;
      chk("mid.wc",    64'(wc0),        64'd0);
      chk("mid.err",   64'(err_o[0]),   64'd0);
      chk("mid.we",    64'(we_o[0]),    64'(BootLoad));
      chk("mid.stall", 64'(stall_o[0]), 64'(BootLoad));
      chk("mid.ready", 64'(ready_o[0]), 64'(BootLoad));
      cycle(1'b0, 1'b1, 32'hC2, 1'b1, 32'h90);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(99) != 0);
         cycle(($urandom_range(15) == 0), ($urandom_range(1) == 1), $urandom(),
               ($urandom_range(7) == 0), $urandom());
      end
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
